piso_tx_sequencer: RTL and testbench
====================================

// Module: piso_tx_sequencer
// PURPOSE
//   Frame controller for the 4-bit parallel-in/serial-out shift register: accepts words over valid/ready,
//   drives its latch/shift strobes and parallel bus, and wraps its serial bit in a start/stop line frame.
//   Sits between an upstream word producer and the PISO; the PISO's serial output feeds back as serial_in.
// PARAMETERS
//   DATA_W     4  word width; equals PISO width; legal >= 2
//   BIT_DIV    4  clk cycles per line bit; legal >= 1
//   STOP_BITS  1  stop bits per frame; legal 1 or 2
// PORTS
//   clk         in   1       rising-edge clock, shared with the PISO
//   rst_n       in   1       asynchronous active-low reset
//   in_data     in   DATA_W  word to transmit
//   in_valid    in   1       in_data valid
//   in_ready    out  1       controller can accept a word (high only in IDLE)
//   par_out     out  DATA_W  word to PISO parallelInput (captured copy)
//   latch_c     out  1       to PISO latchC
//   shift_c     out  1       to PISO shiftC
//   serial_in   in   1       from PISO serialOutput
//   line_out    out  1       framed serial line, idle high
//   busy        out  1       frame in progress (state != IDLE)
//   done        out  1       one-cycle pulse on the last cycle of a frame
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, word reg=0, counters=0; in_ready=1, latch_c=0, shift_c=0,
//   line_out=1, busy=0, done=0, par_out=0. Reset mid-frame aborts immediately; no partial frame resumes.
// - Outputs decode from registered state/counters; line_out in DATA is serial_in passed through.
// - States: IDLE -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE : in_ready=1, line_out=1. in_valid&&in_ready at an edge captures in_data, goes to LOAD.
//   LOAD : exactly 1 cycle; latch_c=1, par_out=captured word; PISO loads at end of cycle; line_out=1.
//   START: BIT_DIV cycles, line_out=0.
//   DATA : DATA_W bits x BIT_DIV cycles, line_out=serial_in (LSB first). shift_c=1 on the last cycle of
//          bits 0..DATA_W-2 only (DATA_W-1 pulses per frame); never with latch_c.
//   STOP : STOP_BITS*BIT_DIV cycles, line_out=1; done=1 on final cycle; next state IDLE.
// - Bit timing: div counter 0..BIT_DIV-1 wraps at BIT_DIV-1 and advances bit counter; bit counter wraps to
//   0 after DATA_W-1 and state advances. BIT_DIV=1: every DATA cycle except the last is a shift cycle.
// - Frame length = 1 + BIT_DIV*(1 + DATA_W + P + STOP_BITS) cycles, P=1 with parity else 0.
// - Back-to-back: in_valid held high -> next word accepted on the IDLE cycle after done; 1 idle cycle min.
// - in_data is ignored while busy; in_valid in non-IDLE states has no effect and is not queued.
// - par_out holds the captured word for the whole frame; changes only at acceptance.
// CONFIGURATION
//   PISO_TX_PARITY_EN defined: PARITY state between DATA and STOP, BIT_DIV cycles,
//     line_out = XOR of the captured word (even parity).
//   Not defined: DATA goes directly to STOP; no parity logic synthesised.
// TESTING
//   (DATA_W=4, BIT_DIV=4, STOP_BITS=1 unless stated)
// - Reset then idle: rst_n low 3 cycles -> in_ready=1, line_out=1, latch_c=shift_c=busy=done=0.
// - Send 4'b1011 -> latch_c 1 cycle; line_out 0x4, then 1,1,0,1 each 4 cycles, then 1x4; exactly 3 shift_c
//   pulses; done on cycle 25 after acceptance.
// - PISO_TX_PARITY_EN, send 4'b1011 -> parity bit 1 for 4 cycles before stop; frame 29 cycles.
// - in_valid held high with 4'hA then 4'h5 -> second accepted 1 cycle after done; in_data changes
//   mid-frame do not alter par_out.
// - rst_n pulsed low mid-DATA -> line_out=1, busy=0 at once; next word transmits complete and correct.
// - BIT_DIV=1, STOP_BITS=2, send 4'b0110 -> line 0,0,1,1,0,1,1; 3 shift_c pulses in consecutive cycles.

Source files
------------

// File: rtl/piso_tx_sequencer_if.sv
// Word stream and PISO-side signals of the PISO frame controller.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready handshake; in_ready high only while the controller is idle.
//   master : word producer / environment (drives in_data, in_valid, serial_in)
//   slave  : piso_tx_sequencer (drives handshake ready, PISO strobes, framed line, status)
interface piso_tx_sequencer_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] par_out;
  logic              latch_c;
  logic              shift_c;
  logic              serial_in;
  logic              line_out;
  logic              busy;
  logic              done;

  modport master (
    output in_data, in_valid, serial_in,
    input  in_ready, par_out, latch_c, shift_c, line_out, busy, done
  );

  modport slave (
    input  in_data, in_valid, serial_in,
    output in_ready, par_out, latch_c, shift_c, line_out, busy, done
  );
endinterface

// File: rtl/piso_tx_sequencer.sv
// Frame controller for a DATA_W-bit PISO: loads the word, strobes shifts, wraps the serial bit in start/stop.
// Latency: word accepted at an edge -> latch_c next cycle; frame = 1 + BIT_DIV*(1+DATA_W+P+STOP_BITS) cycles.
// Backpressure: in_ready high only in IDLE; in_valid outside IDLE is ignored, nothing is queued.
//   Ports: clk, rst_n (async active-low); bus (slave modport): in_data/in_valid/in_ready word handshake,
//   par_out/latch_c/shift_c to the PISO, serial_in from the PISO, line_out framed line, busy, done pulse.
//   Optional macro PISO_TX_PARITY_EN adds an even-parity bit between data and stop bits.
module piso_tx_sequencer #(
  parameter int DATA_W    = 4,
  parameter int BIT_DIV   = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  piso_tx_sequencer_if.slave   bus
);

  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef PISO_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q,   div_d;
  logic [BIT_W-1:0]  bit_q,   bit_d;
  logic [DATA_W-1:0] word_q,  word_d;

  logic div_last;
  logic bit_last;

  assign div_last = (div_q == DIV_LAST);
  assign bit_last = (bit_q == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    word_d  = word_q;
    // Timed states share the divider; it restarts at 0 on every bit boundary.
    if (state_q != S_IDLE && state_q != S_LOAD) begin
      div_d = div_last ? '0 : div_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        div_d   = '0;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (div_last) state_d = S_DATA;
      end
      S_DATA: begin
        if (div_last) begin
          if (bit_last) begin
            bit_d   = '0;
`ifdef PISO_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      S_PARITY: begin
        if (div_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // bit_q doubles as the stop-bit counter.
        if (div_last) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs decode from registered state so they are glitch-free relative to the PISO edge.
  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.latch_c  = (state_q == S_LOAD);
  assign bus.par_out  = word_q;
  // The PISO already presents bit 0 after the load, so only DATA_W-1 shifts are needed.
  assign bus.shift_c  = (state_q == S_DATA) && div_last && !bit_last;
  assign bus.done     = (state_q == S_STOP) && div_last && (bit_q == STOP_LAST);

  always_comb begin
    bus.line_out = 1'b1;
    case (state_q)
      S_START:  bus.line_out = 1'b0;
      S_DATA:   bus.line_out = bus.serial_in;
`ifdef PISO_TX_PARITY_EN
      S_PARITY: bus.line_out = ^word_q;
`endif
      default:  bus.line_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_piso_tx_sequencer.sv
module tb_piso_tx_sequencer;
  localparam int DW = 4;
  localparam int BD = 4;
  localparam int SB = 1;
`ifdef PISO_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [8:0] SEQ1 = 9'b000110011;   // 0, 0,1,1,0, parity 0, 1,1
`else
  localparam int PB = 0;
  localparam logic [8:0] SEQ1 = 9'b000011011;   // 0, 0,1,1,0, 1,1
`endif
  localparam int FL  = 1 + BD * (1 + DW + PB + SB);
  localparam int FL1 = 1 + 1 * (1 + DW + PB + 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  piso_tx_sequencer_if #(.DATA_W(DW)) b0();
  piso_tx_sequencer_if #(.DATA_W(DW)) b1();

  piso_tx_sequencer #(.DATA_W(DW), .BIT_DIV(BD), .STOP_BITS(SB)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  piso_tx_sequencer #(.DATA_W(DW), .BIT_DIV(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  // Behavioural PISO shift registers: load on latchC, shift right on shiftC, LSB on serialOutput.
  logic [DW-1:0] piso0_q = '0;
  logic [DW-1:0] piso1_q = '0;
  always @(posedge clk) begin
    if (b0.latch_c)      piso0_q <= b0.par_out;
    else if (b0.shift_c) piso0_q <= {1'b0, piso0_q[DW-1:1]};
    if (b1.latch_c)      piso1_q <= b1.par_out;
    else if (b1.shift_c) piso1_q <= {1'b0, piso1_q[DW-1:1]};
  end
  assign b0.serial_in = piso0_q[0];
  assign b1.serial_in = piso1_q[0];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // seq lists line bits in send order, MSB first: start, d0, d1, d2, d3, stop.
  typedef struct {
    logic [3:0] data;
    logic [5:0] seq;
    logic       par;
    int         shifts;
  } vec_t;
  vec_t vecs[7];

  function automatic int exp_line(input vec_t v, input int slot);
    if (slot == 0) return int'(v.seq[5]);
    if (slot <= DW) return int'(v.seq[5 - slot]);
    if (PB == 1 && slot == DW + 1) return int'(v.par);
    return int'(v.seq[0]);
  endfunction

  // Checks every cycle of a frame whose word was accepted at the preceding edge.
  task automatic run_frame(input vec_t v, input string tag);
    int slot;
    int ph;
    int shifts;
    shifts = 0;
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, ".latch"}, int'(b0.latch_c), 1);
        chk({tag, ".line"}, int'(b0.line_out), 1);
        chk({tag, ".shift"}, int'(b0.shift_c), 0);
      end else begin
        slot = (k - 2) / BD;
        ph   = (k - 2) % BD;
        chk({tag, ".latch"}, int'(b0.latch_c), 0);
        chk({tag, ".line"}, int'(b0.line_out), exp_line(v, slot));
        chk({tag, ".shift"}, int'(b0.shift_c), int'(slot >= 1 && slot <= DW - 1 && ph == BD - 1));
      end
      if (b0.shift_c) shifts++;
      chk({tag, ".par_out"}, int'(b0.par_out), int'(v.data));
      chk({tag, ".busy"}, int'(b0.busy), 1);
      chk({tag, ".ready"}, int'(b0.in_ready), 0);
      chk({tag, ".done"}, int'(b0.done), int'(k == FL));
    end
    chk({tag, ".shift_count"}, shifts, v.shifts);
  endtask

  task automatic send(input vec_t v, input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!b0.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, ".ready_wait"}, int'(b0.in_ready), 1);
    b0.in_data  = v.data;
    b0.in_valid = 1'b1;
    @(posedge clk);
    #1 b0.in_valid = 1'b0;
    run_frame(v, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int shifts1;
    int prev_shift;
    int consec_ok;

    vecs[0] = '{data: 4'b1011, seq: 6'b011011, par: 1'b1, shifts: 3};
    vecs[1] = '{data: 4'b0000, seq: 6'b000001, par: 1'b0, shifts: 3};
    vecs[2] = '{data: 4'b1111, seq: 6'b011111, par: 1'b0, shifts: 3};
    vecs[3] = '{data: 4'b0110, seq: 6'b001101, par: 1'b0, shifts: 3};
    vecs[4] = '{data: 4'b0101, seq: 6'b010101, par: 1'b0, shifts: 3};
    vecs[5] = '{data: 4'b1010, seq: 6'b001011, par: 1'b0, shifts: 3};
    vecs[6] = '{data: 4'b0001, seq: 6'b010001, par: 1'b1, shifts: 3};

    b0.in_data = '0; b0.in_valid = 1'b0;
    b1.in_data = '0; b1.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.ready", int'(b0.in_ready), 1);
    chk("rst.line", int'(b0.line_out), 1);
    chk("rst.latch", int'(b0.latch_c), 0);
    chk("rst.shift", int'(b0.shift_c), 0);
    chk("rst.busy", int'(b0.busy), 0);
    chk("rst.done", int'(b0.done), 0);
    chk("rst.par_out", int'(b0.par_out), 0);
    chk("rst.line1", int'(b1.line_out), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.line", int'(b0.line_out), 1);
    chk("idle.busy", int'(b0.busy), 0);

    for (int i = 0; i < 7; i++) begin
      send(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back with in_valid held high; in_data changes mid-frame.
    @(negedge clk);
    b0.in_data  = 4'hA;
    b0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin
        repeat (8) @(posedge clk);
        #1 b0.in_data = 4'h5;
      end
    join_none
    run_frame(vecs[5], "b2b_a");
    @(negedge clk);
    chk("b2b.gap_ready", int'(b0.in_ready), 1);
    chk("b2b.gap_busy", int'(b0.busy), 0);
    chk("b2b.gap_line", int'(b0.line_out), 1);
    @(posedge clk);
    #1 b0.in_valid = 1'b0;
    run_frame(vecs[4], "b2b_5");

    // Reset during DATA (cycle 15 after acceptance: bit d2 of 4'b1011, line low).
    @(negedge clk);
    b0.in_data  = 4'b1011;
    b0.in_valid = 1'b1;
    @(posedge clk);
    #1 b0.in_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid.line_pre", int'(b0.line_out), 0);
    chk("mid.busy_pre", int'(b0.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid.line", int'(b0.line_out), 1);
    chk("mid.busy", int'(b0.busy), 0);
    chk("mid.ready", int'(b0.in_ready), 1);
    chk("mid.shift", int'(b0.shift_c), 0);
    chk("mid.done", int'(b0.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(vecs[6], "after_rst");

    // BIT_DIV=1, STOP_BITS=2 instance.
    @(negedge clk);
    b1.in_data  = 4'b0110;
    b1.in_valid = 1'b1;
    @(posedge clk);
    #1 b1.in_valid = 1'b0;
    shifts1    = 0;
    prev_shift = 0;
    consec_ok  = 1;
    for (int k = 1; k <= FL1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("bd1.latch", int'(b1.latch_c), 1);
        chk("bd1.line", int'(b1.line_out), 1);
      end else begin
        chk("bd1.line", int'(b1.line_out), int'(SEQ1[FL1 - k]));
        chk("bd1.shift", int'(b1.shift_c), int'(k >= 3 && k <= 5));
      end
      if (b1.shift_c) begin
        if (shifts1 > 0 && prev_shift == 0) consec_ok = 0;
        shifts1++;
      end
      prev_shift = int'(b1.shift_c);
      chk("bd1.par_out", int'(b1.par_out), 4'b0110);
      chk("bd1.done", int'(b1.done), int'(k == FL1));
    end
    chk("bd1.shift_count", shifts1, 3);
    chk("bd1.shift_consecutive", consec_ok, 1);
    @(negedge clk);
    chk("bd1.idle_ready", int'(b1.in_ready), 1);
    chk("bd1.idle_line", int'(b1.line_out), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
